// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial multi-digit BCD add/subtract (nines' complement, end-around carry)
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active-high
//   start  - request, sampled only while idle
//   op     - 0 = add (a+b), 1 = subtract (a-b)
//   a, b   - packed BCD operands, digit 0 in bits [3:0]
//   busy   - operation in progress
//   done   - one-cycle pulse, results valid
//   diff   - result magnitude, packed BCD
//   sign   - 1 = negative result (subtract only, never negative zero)
//   ovf    - add mode decimal carry out of the MSD
//   err    - non-BCD digit seen on a or b
//
// Optional feature: define BCD_SUB_DIGIT_CHECK_EN to enable the input digit
// check that drives err; otherwise err is tied to 0.
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                sign,
    output logic                ovf,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx;
    logic          c, ec, opr, nz;
    logic [W-1:0]  ra, rb, w, wn;
    logic [3:0]    bx, sa, fd, fr, dig;
    logic [4:0]    s, fx;
    logic          s_hi, fc, last;
`ifdef BCD_SUB_DIGIT_CHECK_EN
    logic          flag;
`endif

    assign busy = state != IDLE;
    assign last = idx == IW'(DIGITS - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = start ? ADD : IDLE;
            ADD:  state_n = last ? FIX : ADD;
            FIX:  state_n = last ? DONE : FIX;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Digit datapath: ADD forms a_i + (b_i or 9-b_i) + c with decimal
    // correction; FIX post-processes the stored digit according to op/ec.
    always_comb begin
        bx   = opr ? 4'd9 - rb[3:0] : rb[3:0];
        s    = {1'b0, ra[3:0]} + {1'b0, bx} + {4'b0, c};
        s_hi = s > 5'd9;
        sa   = s_hi ? s[3:0] + 4'd6 : s[3:0];
        fd   = w[3:0];
        fx   = {1'b0, fd} + {4'b0, c};
        fc   = fx > 5'd9;
        fr   = !opr ? fd : ec ? (fc ? fx[3:0] + 4'd6 : fx[3:0]) : 4'd9 - fd;
        dig  = state == ADD ? sa : fr;
        // Results enter at the MSD end so after DIGITS steps digit 0 is back at [3:0].
        wn   = W'({dig, w} >> 4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            c     <= 1'b0;
            ec    <= 1'b0;
            opr   <= 1'b0;
            nz    <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            w     <= '0;
            done  <= 1'b0;
            diff  <= '0;
            sign  <= 1'b0;
            ovf   <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            flag  <= 1'b0;
            err   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ra   <= a;
                    rb   <= b;
                    opr  <= op;
                    idx  <= '0;
                    c    <= 1'b0;
                    nz   <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                    flag <= 1'b0;
`endif
                end
                ADD: begin
                    w   <= wn;
                    ra  <= ra >> 4;
                    rb  <= rb >> 4;
                    c   <= s_hi;
                    idx <= last ? '0 : idx + IW'(1);
                    if (last) ec <= s_hi;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                    if (ra[3:0] > 4'd9 || rb[3:0] > 4'd9) flag <= 1'b1;
`endif
                end
                FIX: begin
                    w   <= wn;
                    // c already holds ec at entry, seeding the +1 ripple
                    if (opr && ec) c <= fc;
                    idx <= last ? '0 : idx + IW'(1);
                    nz  <= nz | (fr != 4'd0);
                end
                DONE: begin
                    diff <= w;
                    sign <= opr & ~ec & nz;
                    ovf  <= ~opr & ec;
                    done <= 1'b1;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                    err  <= flag;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef BCD_SUB_DIGIT_CHECK_EN
    assign err = 1'b0;
`endif
endmodule
